// File: rtl/barrel_pixel_fetch.sv
`default_nettype none
// ============================================================================
// Module      : barrel_pixel_fetch
// Description : Converts centred signed source coordinates from the barrel
//               distortion math stage into frame-buffer word addresses. It
//               issues in-order reads and returns the fetched pixels as an
//               in-order stream. Out-of-frame coordinates skip memory and
//               yield black. It also drives the math-stage backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module barrel_pixel_fetch #(
    parameter int WIDTH  = 960,
    parameter int HEIGHT = 1080,
    parameter int ADDR_W = 20,
    parameter int PIX_W  = 24,
    parameter int DEPTH  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic signed [11:0]  xIn,
    input  logic signed [11:0]  yIn,
    input  logic                addr_vld,
    output logic                mem_ready,
    output logic [ADDR_W-1:0]   rd_addr,
    output logic                rd_req,
    input  logic                rd_gnt,
    input  logic [PIX_W-1:0]    rd_data,
    input  logic                rd_dvld,
    output logic [PIX_W-1:0]    pix_out,
    output logic                pix_vld,
    input  logic                pix_rdy,
    output logic                err_spur
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic signed [12:0] c_width  = 13'(WIDTH);
    localparam logic signed [12:0] c_height = 13'(HEIGHT);
    localparam logic signed [12:0] c_half_w = 13'(WIDTH / 2);
    localparam logic signed [12:0] c_half_h = 13'(HEIGHT / 2);
    localparam logic [CW-1:0]      c_depth  = CW'(DEPTH);
    localparam logic [CW-1:0]      c_one    = CW'(1);
    localparam logic [AW-1:0]      c_ptr1   = AW'(1);

    // Pipeline stage S1: frame-relative column/row
    logic                    r_s1_vld;
    logic signed [12:0]      r_s1_col;
    logic signed [12:0]      r_s1_row;
    // Pipeline stage S2: word address and in-bounds flag
    logic                    r_s2_vld;
    logic                    r_s2_inb;
    logic [ADDR_W-1:0]       r_s2_addr;
    // Order FIFO: one flag per accepted coordinate (1 = memory read issued)
    logic [DEPTH-1:0]        r_ord_flags;
    logic [AW-1:0]           r_ord_wr;
    logic [AW-1:0]           r_ord_rd;
    logic [CW-1:0]           r_ord_cnt;
    // Data FIFO: returned pixels
    logic [PIX_W-1:0]        r_dat_mem [DEPTH];
    logic [AW-1:0]           r_dat_wr;
    logic [AW-1:0]           r_dat_rd;
    logic [CW-1:0]           r_dat_cnt;
    // Granted in-bounds reads whose data has not yet come back
    logic [CW-1:0]           r_out_cnt;
    logic                    r_err_spur;

    logic                    w_accept;
    logic                    w_s1_inb;
    logic [ADDR_W-1:0]       w_s1_addr;
    logic                    w_s1_adv;
    logic                    w_s2_retire;
    logic                    w_ord_full;
    logic                    w_ord_push;
    logic                    w_head_flag;
    logic                    w_fire;
    logic                    w_dat_push;
    logic                    w_dat_pop;
    logic                    w_out_inc;

    // Bounds test and constant-multiply address generation from S1
    assign w_s1_inb  = !r_s1_col[12] && (r_s1_col < c_width) &&
                       !r_s1_row[12] && (r_s1_row < c_height);
    assign w_s1_addr = ADDR_W'(r_s1_row) * ADDR_W'(WIDTH) + ADDR_W'(r_s1_col);

    // Pipeline advance: an S2 entry leaves once its order flag can be pushed,
    // and an in-bounds entry additionally needs the memory grant.
    assign w_ord_full  = (r_ord_cnt == c_depth);
    assign w_s2_retire = r_s2_vld && !w_ord_full && (!r_s2_inb || rd_gnt);
    assign w_s1_adv    = r_s1_vld && (!r_s2_vld || w_s2_retire);
    assign mem_ready   = !reset && (!r_s1_vld || w_s1_adv);
    assign w_accept    = addr_vld && mem_ready;

    assign rd_req  = r_s2_vld && r_s2_inb && !w_ord_full;
    assign rd_addr = r_s2_addr;

    assign w_ord_push = w_s2_retire;
    assign w_out_inc  = w_s2_retire && r_s2_inb;
    // Returns with nothing outstanding are dropped and flagged
    assign w_dat_push = rd_dvld && (r_out_cnt != '0);

    // Output selection from the order FIFO head
    assign w_head_flag = r_ord_flags[r_ord_rd];
    assign pix_vld     = (r_ord_cnt != '0) && (!w_head_flag || (r_dat_cnt != '0));
    assign pix_out     = (pix_vld && w_head_flag) ? r_dat_mem[r_dat_rd] : '0;
    assign w_fire      = pix_vld && pix_rdy;
    assign w_dat_pop   = w_fire && w_head_flag;
    assign err_spur    = r_err_spur;

    // S1 register: capture re-centred coordinates on handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_vld <= 1'b0;
            r_s1_col <= '0;
            r_s1_row <= '0;
        end else if (w_accept) begin
            r_s1_vld <= 1'b1;
            r_s1_col <= {xIn[11], xIn} + c_half_w;
            r_s1_row <= {yIn[11], yIn} + c_half_h;
        end else if (w_s1_adv) begin
            r_s1_vld <= 1'b0;
        end
    end

    // S2 register: hold address until the entry retires
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s2_vld  <= 1'b0;
            r_s2_inb  <= 1'b0;
            r_s2_addr <= '0;
        end else if (w_s1_adv) begin
            r_s2_vld  <= 1'b1;
            r_s2_inb  <= w_s1_inb;
            r_s2_addr <= w_s1_addr;
        end else if (w_s2_retire) begin
            r_s2_vld  <= 1'b0;
        end
    end

    // Order FIFO pointers, occupancy and flag storage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ord_flags <= '0;
            r_ord_wr    <= '0;
            r_ord_rd    <= '0;
            r_ord_cnt   <= '0;
        end else begin
            if (w_ord_push) begin
                r_ord_flags[r_ord_wr] <= r_s2_inb;
                r_ord_wr              <= r_ord_wr + c_ptr1;
            end
            if (w_fire) begin
                r_ord_rd <= r_ord_rd + c_ptr1;
            end
            case ({w_ord_push, w_fire})
                2'b10:   r_ord_cnt <= r_ord_cnt + c_one;
                2'b01:   r_ord_cnt <= r_ord_cnt - c_one;
                default: r_ord_cnt <= r_ord_cnt;
            endcase
        end
    end

    // Data FIFO storage; contents need no reset since occupancy gates use
    always_ff @(posedge clk) begin
        if (w_dat_push) begin
            r_dat_mem[r_dat_wr] <= rd_data;
        end
    end

    // Data FIFO pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dat_wr  <= '0;
            r_dat_rd  <= '0;
            r_dat_cnt <= '0;
        end else begin
            if (w_dat_push) begin
                r_dat_wr <= r_dat_wr + c_ptr1;
            end
            if (w_dat_pop) begin
                r_dat_rd <= r_dat_rd + c_ptr1;
            end
            case ({w_dat_push, w_dat_pop})
                2'b10:   r_dat_cnt <= r_dat_cnt + c_one;
                2'b01:   r_dat_cnt <= r_dat_cnt - c_one;
                default: r_dat_cnt <= r_dat_cnt;
            endcase
        end
    end

    // Outstanding-read tracking and sticky spurious-return flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_cnt  <= '0;
            r_err_spur <= 1'b0;
        end else begin
            case ({w_out_inc, w_dat_push})
                2'b10:   r_out_cnt <= r_out_cnt + c_one;
                2'b01:   r_out_cnt <= r_out_cnt - c_one;
                default: r_out_cnt <= r_out_cnt;
            endcase
            if (rd_dvld && (r_out_cnt == '0)) begin
                r_err_spur <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_barrel_pixel_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_barrel_pixel_fetch
// Description : Directed bench for barrel_pixel_fetch with a latency-
//               programmable memory model and an in-order pixel scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_barrel_pixel_fetch;

    localparam int DEPTH = 16;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic signed [11:0] xIn = '0;
    logic signed [11:0] yIn = '0;
    logic               addr_vld = 1'b0;
    logic               mem_ready;
    logic [19:0]        rd_addr;
    logic               rd_req;
    logic               rd_gnt = 1'b1;
    logic [23:0]        rd_data = '0;
    logic               rd_dvld = 1'b0;
    logic [23:0]        pix_out;
    logic               pix_vld;
    logic               pix_rdy = 1'b1;
    logic               err_spur;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [19:0] a;
        int          due;
    } req_t;

    req_t        pend[$];
    logic [23:0] exp_q[$];
    int          cyc = 0;
    int          lat = 1;
    int          grants = 0;
    bit          gnt_rand = 1'b0;
    bit          spur_req = 1'b0;

    barrel_pixel_fetch #(
        .WIDTH (960),
        .HEIGHT(1080),
        .ADDR_W(20),
        .PIX_W (24),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .xIn      (xIn),
        .yIn      (yIn),
        .addr_vld (addr_vld),
        .mem_ready(mem_ready),
        .rd_addr  (rd_addr),
        .rd_req   (rd_req),
        .rd_gnt   (rd_gnt),
        .rd_data  (rd_data),
        .rd_dvld  (rd_dvld),
        .pix_out  (pix_out),
        .pix_vld  (pix_vld),
        .pix_rdy  (pix_rdy),
        .err_spur (err_spur)
    );

    always #5 clk = ~clk;

    // Reference mapping: centred coordinate to expected pixel (data == address)
    function automatic logic [23:0] exp_pix(input int x, input int y);
        int col;
        int row;
        col = x + 480;
        row = y + 540;
        if (col >= 0 && col < 960 && row >= 0 && row < 1080)
            return 24'(row * 960 + col);
        return 24'd0;
    endfunction

    // Memory model: record grants seen before the edge
    always @(negedge clk) begin
        if (!reset && rd_req && rd_gnt) begin
            pend.push_back('{a: rd_addr, due: cyc + lat});
            grants++;
        end
    end

    // Memory model: drive returns and grant just after each edge
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        rd_dvld = 1'b0;
        rd_data = '0;
        if (pend.size() != 0 && pend[0].due <= cyc) begin
            rd_dvld = 1'b1;
            rd_data = {4'h0, pend[0].a};
            void'(pend.pop_front());
        end else if (spur_req && pend.size() == 0) begin
            rd_dvld  = 1'b1;
            rd_data  = 24'hABCDEF;
            spur_req = 1'b0;
        end
        rd_gnt = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Output scoreboard
    always @(negedge clk) begin
        if (!reset && pix_vld && pix_rdy) begin
            tests++;
            assert (exp_q.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_pixel: got %0d, none expected", pix_out);
            end
            if (exp_q.size() != 0) begin
                logic [23:0] e;
                e = exp_q.pop_front();
                assert (pix_out === e) else begin
                    fails++;
                    $error("FAIL pix_order: got %0d expected %0d", pix_out, e);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one coordinate and hold it until accepted
    task automatic send(input int x, input int y);
        int n;
        n = 0;
        xIn = 12'(x);
        yIn = 12'(y);
        addr_vld = 1'b1;
        @(negedge clk);
        while (!mem_ready && n < 300) begin
            n++;
            @(negedge clk);
        end
        chk("accept", 32'(mem_ready), 1);
        if (mem_ready) exp_q.push_back(exp_pix(x, y));
        tick();
        addr_vld = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || pend.size() != 0) && n < 3000) begin
            n++;
            @(negedge clk);
        end
        chk("drain", 32'(exp_q.size() + pend.size()), 0);
        tick();
    endtask

    // Accepted coordinate shows up on rd_addr the cycle after E1
    task automatic check_addr(input int x, input int y, input int a);
        send(x, y);
        @(negedge clk);
        @(negedge clk);
        chk("rd_req_inb", 32'(rd_req), 1);
        chk("rd_addr", 32'(rd_addr), 32'(a));
        tick();
    endtask

    // Out-of-bounds: no read, black pixel three cycles after accept
    task automatic check_oob(input int x, input int y);
        int g0;
        g0 = grants;
        send(x, y);
        @(negedge clk);
        @(negedge clk);
        chk("rd_req_oob", 32'(rd_req), 0);
        @(negedge clk);
        chk("oob_pix_vld", 32'(pix_vld), 1);
        chk("oob_pix_out", 32'(pix_out), 0);
        chk("oob_no_grant", 32'(grants), 32'(g0));
        tick();
    endtask

    initial begin
        int          accepted;
        logic [23:0] held;
        int          g0;
        int          n;

        // Reset values
        #1;
        repeat (2) tick();
        chk("rst_mem_ready", 32'(mem_ready), 0);
        chk("rst_rd_req", 32'(rd_req), 0);
        chk("rst_rd_addr", 32'(rd_addr), 0);
        chk("rst_pix_vld", 32'(pix_vld), 0);
        chk("rst_pix_out", 32'(pix_out), 0);
        chk("rst_err_spur", 32'(err_spur), 0);
        reset = 1'b0;
        tick();

        // In-bounds mapping
        check_addr(0, 0, 518880);
        check_addr(-480, -540, 0);
        check_addr(479, 539, 1036799);
        drain();

        // Out-of-bounds
        check_oob(480, 0);
        check_oob(0, -541);
        check_oob(-2048, 2047);
        drain();

        // Ordering with long latency and random grants
        lat = 7;
        gnt_rand = 1'b1;
        for (int i = 0; i < 24; i++) begin
            if (i % 2 == 0)
                send(int'($urandom_range(0, 959)) - 480, int'($urandom_range(0, 1079)) - 540);
            else
                send(480 + int'($urandom_range(0, 100)), int'($urandom_range(0, 20)) - 10);
        end
        drain();
        gnt_rand = 1'b0;
        lat = 1;

        // Backpressure: stall output with a continuous input stream
        pix_rdy = 1'b0;
        accepted = 0;
        held = '0;
        for (int c = 0; c < 40; c++) begin
            xIn = 12'(c - 20);
            yIn = 12'(c);
            addr_vld = 1'b1;
            @(negedge clk);
            if (mem_ready) begin
                accepted++;
                exp_q.push_back(exp_pix(c - 20, c));
            end
            if (c == 30) held = pix_out;
            tick();
        end
        addr_vld = 1'b0;
        @(negedge clk);
        chk("bp_mem_ready", 32'(mem_ready), 0);
        chk("bp_accepted", 32'(accepted), DEPTH + 2);
        chk("bp_pix_vld", 32'(pix_vld), 1);
        chk("bp_stable", 32'(pix_out), 32'(held));
        chk("bp_head", 32'(pix_out), 32'(exp_q[0]));
        tick();
        pix_rdy = 1'b1;
        drain();

        // Spurious return
        spur_req = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        chk("spur_set", 32'(err_spur), 1);
        chk("spur_no_pix", 32'(pix_vld), 0);
        tick();
        send(10, 10);
        drain();
        chk("spur_sticky", 32'(err_spur), 1);

        // Reset with reads outstanding
        lat = 20;
        g0 = grants;
        for (int i = 0; i < 5; i++) send(i * 3, i * 2);
        n = 0;
        while (grants < g0 + 5 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("mid_grants", 32'(grants - g0), 5);
        tick();
        reset = 1'b1;
        #1;
        chk("mid_mem_ready", 32'(mem_ready), 0);
        chk("mid_rd_req", 32'(rd_req), 0);
        chk("mid_rd_addr", 32'(rd_addr), 0);
        chk("mid_pix_vld", 32'(pix_vld), 0);
        chk("mid_pix_out", 32'(pix_out), 0);
        chk("mid_err_spur", 32'(err_spur), 0);
        exp_q.delete();
        repeat (2) tick();
        reset = 1'b0;
        n = 0;
        while (pend.size() != 0 && n < 100) begin
            n++;
            @(negedge clk);
        end
        @(negedge clk);
        chk("stale_err_spur", 32'(err_spur), 1);
        tick();
        lat = 1;
        check_addr(0, 0, 518880);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
